rr_issue_arbiter: RTL and testbench

//  Stateful round-robin arbiter: N valid/ready requesters share one registered output port.

---
 rtl/rr_issue_arbiter.sv | 95 +++++++++
 tb/tb_rr_issue_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rr_issue_arbiter.sv
// Round-robin arbiter: N valid/ready requesters share one registered output port.
// Optional payload path is enabled by defining RR_ARB_PAYLOAD_EN.
module rr_issue_arbiter #(
    parameter int N      = 4,
    parameter int IDX_W  = $clog2(N),
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic [N-1:0]        req_valid,
    output logic [N-1:0]        req_ready,
`ifdef RR_ARB_PAYLOAD_EN
    input  logic [N*DATA_W-1:0] req_data,
    output logic [DATA_W-1:0]   out_data,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_onehot,
    output logic [IDX_W-1:0]    out_idx
);

    logic [N-1:0]     base;
    logic [N-1:0]     mask_hi;
    logic [N-1:0]     req_hi;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             load;

    function automatic logic [IDX_W-1:0] enc(input logic [N-1:0] onehot);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

    // Bits at or above base get first pick; fall back to the lowest set bit to wrap.
    always_comb begin
        mask_hi = ~(base - N'(1));
        req_hi  = req_valid & mask_hi;
        if (|req_hi) grant = req_hi & (~req_hi + N'(1));
        else         grant = req_valid & (~req_valid + N'(1));
        grant_idx = enc(grant);
    end

    assign load      = (~out_valid | out_ready) & ~flush;
    assign req_ready = (load & ~reset) ? grant : '0;

`ifdef RR_ARB_PAYLOAD_EN
    logic [DATA_W-1:0] data_sel;

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) data_sel = data_sel | req_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clock) begin
        if (reset)                  out_data <= '0;
        else if (load && (|grant))  out_data <= data_sel;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            base       <= N'(1);
            out_valid  <= 1'b0;
            out_onehot <= '0;
            out_idx    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            if (|grant) begin
                out_valid  <= 1'b1;
                out_onehot <= grant;
                out_idx    <= grant_idx;
                base       <= {grant[N-2:0], grant[N-1]};
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    always @(posedge clock) begin
        if (!reset) begin
            assert ($onehot0(out_onehot));
            assert ($onehot0(req_ready));
            assert (out_idx == enc(out_onehot));
        end
    end

endmodule

// File: tb/tb_rr_issue_arbiter.sv
// Directed bench for rr_issue_arbiter (N=4); grants are queued when accepted and
// checked against the registered output one cycle later.
module tb_rr_issue_arbiter;

    localparam int N      = 4;
    localparam int IDX_W  = 2;
    localparam int DATA_W = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic             flush;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_onehot;
    logic [IDX_W-1:0] out_idx;
`ifdef RR_ARB_PAYLOAD_EN
    logic [N*DATA_W-1:0] req_data;
    logic [DATA_W-1:0]   out_data;
`endif

    int total = 0;
    int bad   = 0;
    logic [N-1:0] sb_q[$];
    logic [N-1:0] cur_exp = '0;

    rr_issue_arbiter #(.N(N), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
`ifdef RR_ARB_PAYLOAD_EN
        .req_data   (req_data),
        .out_data   (out_data),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_idx    (out_idx)
    );

    always #5 clock = ~clock;

    function automatic logic [IDX_W-1:0] idx_of(input logic [N-1:0] oh);
        case (oh)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs just after an edge, check req_ready mid-cycle,
    // then check the registered output just after the next edge.
    task automatic cycle(input string tag, input logic [N-1:0] rv, input logic ordy,
                         input logic fl, input logic [N-1:0] exp_ready, input logic exp_ov);
        req_valid = rv;
        out_ready = ordy;
        flush     = fl;
        #3;
        check({tag, ".req_ready"}, 32'(req_ready), 32'(exp_ready));
        if (exp_ready != '0) sb_q.push_back(exp_ready);
        @(posedge clock);
        #1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
        if (exp_ready != '0) begin
            if (sb_q.size() == 0) begin
                total++; bad++;
                $error("FAIL %s.queue: observed=empty expected=entry", tag);
            end else begin
                cur_exp = sb_q.pop_front();
            end
        end
        if (exp_ov) begin
            check({tag, ".out_onehot"}, 32'(out_onehot), 32'(cur_exp));
            check({tag, ".out_idx"}, 32'(out_idx), 32'(idx_of(cur_exp)));
        end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
`ifdef RR_ARB_PAYLOAD_EN
        req_data  = '0;
`endif
        @(posedge clock);
        #1;

        // Reset held with all requesting: nothing accepted.
        cycle("rst0", 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0);
        cycle("rst1", 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0);
        reset = 1'b0;

        // Full rotation from base=0001.
        cycle("rot0", 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1);
        cycle("rot1", 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1);
        cycle("rot2", 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1);
        cycle("rot3", 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1);
        cycle("rot4", 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1);

        // Sparse requesters alternate; idle cycle keeps base.
        cycle("alt0", 4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1);
        cycle("alt1", 4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1);
        cycle("alt2", 4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1);
        cycle("alt3", 4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1);
        cycle("idle0", 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        cycle("idle1", 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
        cycle("hold0", 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1);
        cycle("hold1", 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1);

        // Backpressure on an idx2 grant.
        cycle("bp0", 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1);
        cycle("bp1", 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1);
        cycle("bp2", 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1);
        cycle("bp3", 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1);
        cycle("bp4", 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1);

        // Flush under backpressure; base stays at 0001.
        cycle("fl0", 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0);
        cycle("fl1", 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1);
        // Flush with consumer ready also blocks acceptance.
        cycle("fl2", 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0);
        cycle("fl3", 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1);

        // Wrap: base=0100, only bit 0 requesting.
        cycle("wrap", 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1);

        // Reset mid-transfer restores base to 0001 (base was 0010).
        reset = 1'b1;
        cycle("rst2", 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0);
        reset = 1'b0;
        cycle("post", 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1);

`ifdef RR_ARB_PAYLOAD_EN
        for (int i = 0; i < N; i++) req_data[i*DATA_W +: DATA_W] = 32'hA000_0000 | 32'(i);
        cycle("pay0", 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1);
        check("pay0.out_data", out_data, 32'hA000_0002);
        req_data = '0;
        cycle("pay1", 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1);
        check("pay1.out_data", out_data, 32'hA000_0002);
`endif

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
